// File: rtl/mem_request_arbiter.sv
// ---------------------------------------------------------------------------
// mem_request_arbiter
//
// Arbitrates the instruction-fetch channel and the data (load/store) channel
// onto a single shared memory port. The granted request is registered onto
// the memory port and held stable until ram_ready is seen. A one-cycle hit
// pulse (ihit or dhit) then returns on the owning channel, with the load data
// registered into iload/dload. If ram_ready never arrives within MAX_WAIT
// cycles, the access is abandoned and a one-cycle err pulse is returned in
// place of the hit.
//
// Arbitration: data requests normally win. An instruction request that is
// left waiting is guaranteed a grant after at most MAX_DBURST consecutive
// data grants.
//
// Optional feature: define REQ_STATS_EN to add the icount/dcount/stalls
// statistics outputs and the CNT_W parameter.
//
// Ports:
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   iren       in   instruction read request
//   iaddr      in   instruction address
//   dren       in   data read request
//   dwen       in   data write request (takes priority over dren)
//   daddr      in   data address
//   dstore     in   store data
//   ihit       out  one-cycle instruction completion, iload valid
//   dhit       out  one-cycle data completion, dload valid for reads
//   iload      out  last fetched instruction
//   dload      out  last loaded data word
//   err        out  one-cycle timeout pulse (replaces the hit)
//   ram_ren    out  registered memory read strobe
//   ram_wen    out  registered memory write strobe
//   ram_addr   out  registered memory address
//   ram_store  out  registered memory write data
//   ram_load   in   memory read data
//   ram_ready  in   memory access completes this cycle
//   icount     out  completed instruction accesses  (REQ_STATS_EN)
//   dcount     out  completed data accesses         (REQ_STATS_EN)
//   stalls     out  cycles spent waiting on memory  (REQ_STATS_EN)
// ---------------------------------------------------------------------------
module mem_request_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_DBURST = 4,
    parameter int unsigned MAX_WAIT   = 255
`ifdef REQ_STATS_EN
    ,
    parameter int unsigned CNT_W      = 32
`endif
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dren,
    input  logic              dwen,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              err,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
`ifdef REQ_STATS_EN
    ,
    output logic [CNT_W-1:0]  icount,
    output logic [CNT_W-1:0]  dcount,
    output logic [CNT_W-1:0]  stalls
`endif
);

    // burst_cnt counts 0..MAX_DBURST; wait_cnt counts 0..MAX_WAIT-1.
    localparam int unsigned BURST_W = $clog2(MAX_DBURST + 1);
    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_DBURST);
    localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StInstr,
        StData,
        StDone
    } state_t;

    state_t             state;
    logic [BURST_W-1:0] burst_cnt;
    logic [WAIT_W-1:0]  wait_cnt;

    logic data_req;
    logic data_win;

    assign data_req = dren | dwen;

    // Data wins unless an instruction request has already waited through a
    // full burst of data grants.
    assign data_win = data_req & ((burst_cnt < BURST_LIMIT) | ~iren);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= StIdle;
            burst_cnt <= '0;
            wait_cnt  <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            iload     <= '0;
            dload     <= '0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Completion pulses only live for the single DONE cycle.
            ihit <= 1'b0;
            dhit <= 1'b0;
            err  <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (data_win) begin
                        state     <= StData;
                        // Only grants taken while an instruction waits count
                        // towards the burst limit.
                        burst_cnt <= iren ? burst_cnt + BURST_W'(1) : '0;
                        wait_cnt  <= '0;
                        ram_addr  <= daddr;
                        ram_store <= dstore;
                        ram_wen   <= dwen;
                        ram_ren   <= ~dwen;
                    end else if (iren) begin
                        state     <= StInstr;
                        burst_cnt <= '0;
                        wait_cnt  <= '0;
                        ram_addr  <= iaddr;
                        ram_wen   <= 1'b0;
                        ram_ren   <= 1'b1;
                    end
                end

                StInstr, StData: begin
                    // ram_ready takes precedence over a same-cycle timeout.
                    if (ram_ready) begin
                        if (state == StInstr) begin
                            iload <= ram_load;
                            ihit  <= 1'b1;
                        end else begin
                            // Writes leave dload untouched.
                            if (ram_ren) begin
                                dload <= ram_load;
                            end
                            dhit <= 1'b1;
                        end
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        state   <= StDone;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err     <= 1'b1;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        state   <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                StDone: begin
                    // Requests are deliberately not sampled here so the
                    // requester has a cycle to react to its hit.
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef REQ_STATS_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            icount <= '0;
            dcount <= '0;
            stalls <= '0;
        end else begin
            if ((state == StInstr) && ram_ready) begin
                icount <= icount + CNT_W'(1);
            end
            if ((state == StData) && ram_ready) begin
                dcount <= dcount + CNT_W'(1);
            end
            if ((state == StInstr) || (state == StData)) begin
                stalls <= stalls + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_request_arbiter
//
// Randomized bench with a transaction-level reference model. Two requester
// models (instruction and data) raise requests and hold them until their
// access completes; a memory model answers each strobe after a random delay
// or never (timeout). The reference model predicts every memory-port grant
// and every completion, pushing them into queues; a monitor on the opposite
// clock edge pops and compares whenever the DUT shows a strobe or a pulse.
// ---------------------------------------------------------------------------
module tb_mem_request_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MAX_DBURST = 4;
    localparam int MAX_WAIT   = 8;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              iren;
    logic [ADDR_W-1:0] iaddr;
    logic              dren;
    logic              dwen;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;
    logic              err;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic [DATA_W-1:0] ram_load;
    logic              ram_ready;
`ifdef REQ_STATS_EN
    logic [31:0]       icount;
    logic [31:0]       dcount;
    logic [31:0]       stalls;
`endif

    mem_request_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_DBURST (MAX_DBURST),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .iren      (iren),
        .iaddr     (iaddr),
        .dren      (dren),
        .dwen      (dwen),
        .daddr     (daddr),
        .dstore    (dstore),
        .ihit      (ihit),
        .dhit      (dhit),
        .iload     (iload),
        .dload     (dload),
        .err       (err),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready)
`ifdef REQ_STATS_EN
        ,
        .icount    (icount),
        .dcount    (dcount),
        .stalls    (stalls)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        int          at;
    } grant_t;

    typedef struct {
        logic        ih;
        logic        dh;
        logic        er;
        logic [31:0] il;
        logic [31:0] dl;
        int          at;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    grant_t cur_g;
    bit     g_valid     = 1'b0;
    bit     strobe_prev = 1'b0;

    always @(negedge clk) begin
        if (!n_rst) begin
            g_valid     = 1'b0;
            strobe_prev = 1'b0;
        end else begin
            if ((ram_ren || ram_wen) && !strobe_prev) begin
                if (gq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_grant: ren=%0b wen=%0b addr=0x%08h, none expected",
                             ram_ren, ram_wen, ram_addr);
                end else begin
                    cur_g   = gq.pop_front();
                    g_valid = 1'b1;
                    check("grant_cycle", cyc, cur_g.at);
                end
            end
            if ((ram_ren || ram_wen) && g_valid) begin
                check("ram_ren", {31'd0, ram_ren}, {31'd0, cur_g.ren});
                check("ram_wen", {31'd0, ram_wen}, {31'd0, cur_g.wen});
                check("ram_addr", ram_addr, cur_g.addr);
                if (cur_g.wen) check("ram_store", ram_store, cur_g.store);
            end
            strobe_prev = ram_ren || ram_wen;

            if (ihit || dhit || err) begin
                if (dq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_done: ihit=%0b dhit=%0b err=%0b, none expected",
                             ihit, dhit, err);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    check("done_kind", {29'd0, ihit, dhit, err}, {29'd0, d.ih, d.dh, d.er});
                    check("done_cycle", cyc, d.at);
                    check("iload", iload, d.il);
                    check("dload", dload, d.dl);
                    check("strobes_clear", {30'd0, ram_ren, ram_wen}, 32'd0);
                    g_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model + stimulus ----------------
    typedef enum {MIdle, MBusy, MDone} mstate_e;

    mstate_e     ms        = MIdle;
    int          burst     = 0;
    int          wcnt      = 0;
    int          resp_k    = 0;
    int          force_k   = 0;
    bit          cur_instr = 1'b0;
    bit          cur_write = 1'b0;
    logic [31:0] m_iload   = '0;
    logic [31:0] m_dload   = '0;
    int          m_icnt    = 0;
    int          m_dcnt    = 0;
    int          m_stall   = 0;

    bit          ipend = 1'b0;
    bit          dpend = 1'b0;
    bit          dwr   = 1'b0;
    logic [31:0] ia = '0;
    logic [31:0] da = '0;
    logic [31:0] ds = '0;

    task automatic pick_response();
        int r;
        r = int'($urandom_range(0, 9));
        if (force_k != 0)  resp_k = force_k;
        else if (r == 0)   resp_k = MAX_WAIT + 1;     // memory never answers
        else if (r == 1)   resp_k = MAX_WAIT;         // ready ties with timeout
        else if (r == 2)   resp_k = int'($urandom_range(1, MAX_WAIT));
        else               resp_k = int'($urandom_range(1, 2));
    endtask

    // One clock: advance the model on the inputs the DUT just sampled, then
    // drive the inputs for the next edge.
    task automatic step(input int pct);
        grant_t g;
        done_t  d;
        @(posedge clk);
        #1;
        case (ms)
            MIdle: begin
                if (dpend && (burst < MAX_DBURST || !ipend)) begin
                    burst     = ipend ? burst + 1 : 0;
                    cur_instr = 1'b0;
                    cur_write = dwr;
                    g.ren = !dwr; g.wen = dwr; g.addr = da; g.store = ds; g.at = cyc;
                    gq.push_back(g);
                    ms = MBusy; wcnt = 0;
                    pick_response();
                end else if (ipend) begin
                    burst     = 0;
                    cur_instr = 1'b1;
                    cur_write = 1'b0;
                    g.ren = 1'b1; g.wen = 1'b0; g.addr = ia; g.store = '0; g.at = cyc;
                    gq.push_back(g);
                    ms = MBusy; wcnt = 0;
                    pick_response();
                end
            end
            MBusy: begin
                wcnt++;
                m_stall++;
                if (ram_ready) begin
                    if (cur_instr) begin
                        m_iload = ram_load;
                        m_icnt++;
                    end else begin
                        if (!cur_write) m_dload = ram_load;
                        m_dcnt++;
                    end
                    d.ih = cur_instr; d.dh = !cur_instr; d.er = 1'b0;
                    d.il = m_iload; d.dl = m_dload; d.at = cyc;
                    dq.push_back(d);
                    if (cur_instr) ipend = 1'b0; else dpend = 1'b0;
                    ms = MDone;
                end else if (wcnt == MAX_WAIT) begin
                    d.ih = 1'b0; d.dh = 1'b0; d.er = 1'b1;
                    d.il = m_iload; d.dl = m_dload; d.at = cyc;
                    dq.push_back(d);
                    if (cur_instr) ipend = 1'b0; else dpend = 1'b0;
                    ms = MDone;
                end
            end
            default: ms = MIdle;
        endcase

        if (!ipend && int'($urandom_range(0, 99)) < pct) begin
            ipend = 1'b1;
            ia    = $urandom;
        end
        if (!dpend && int'($urandom_range(0, 99)) < pct) begin
            dpend = 1'b1;
            dwr   = 1'($urandom_range(0, 1));
            da    = $urandom;
            ds    = $urandom;
        end

        // While an access is in flight its own channel inputs are scrambled;
        // the latched request must not change.
        iren   = ipend;
        iaddr  = (ms == MBusy && cur_instr) ? $urandom : ia;
        dwen   = dpend && dwr;
        dren   = dpend && (!dwr || 1'($urandom_range(0, 1)));
        daddr  = (ms == MBusy && !cur_instr) ? $urandom : da;
        dstore = (ms == MBusy && !cur_instr) ? $urandom : ds;
        ram_load  = $urandom;
        ram_ready = (ms == MBusy) ? (wcnt + 1 == resp_k) : 1'($urandom_range(0, 3) == 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && !(ms == MIdle && !ipend && !dpend); i++) step(0);
        repeat (3) step(0);
    endtask

    initial begin
        n_rst = 1'b0;
        iren = 1'b0; iaddr = '0; dren = 1'b0; dwen = 1'b0; daddr = '0; dstore = '0;
        ram_load = '0; ram_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_dhit", {31'd0, dhit}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_store", ram_store, 32'd0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Simultaneous instr + write: data must go first.
        ipend = 1'b1; ia = 32'h40;
        dpend = 1'b1; dwr = 1'b1; da = 32'h80; ds = 32'h1234;
        iren = 1'b1; iaddr = ia; dwen = 1'b1; dren = 1'b0; daddr = da; dstore = ds;
        drain();

        for (int t = 0; t < 1000; t++) step(50);
        for (int t = 0; t < 1000; t++) step(95);   // saturated: exercises burst limit
        for (int t = 0; t < 600; t++) step(20);
        drain();

        vectors++;
        if (gq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL leftover: grants=%0d completions=%0d still expected",
                     gq.size(), dq.size());
        end
`ifdef REQ_STATS_EN
        check("icount", icount, m_icnt);
        check("dcount", dcount, m_dcnt);
        check("stalls", stalls, m_stall);
`endif

        // Reset in the middle of a write that memory never answers.
        force_k = MAX_WAIT + 1;
        dpend = 1'b1; dwr = 1'b1; da = 32'h80; ds = 32'h55AA;
        iren = 1'b0; dwen = 1'b1; dren = 1'b0; daddr = da; dstore = ds;
        step(0);
        step(0);
        @(negedge clk);
        check("mid_ram_wen", {31'd0, ram_wen}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("arst_ram_wen", {31'd0, ram_wen}, 32'd0);
        check("arst_ram_addr", ram_addr, 32'd0);
        ms = MIdle; burst = 0; dpend = 1'b0; ipend = 1'b0; force_k = 0;
        m_iload = '0; m_dload = '0;
        dwen = 1'b0; dren = 1'b0; iren = 1'b0; ram_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int t = 0; t < 20; t++) step(0);
        check("post_rst_dload", dload, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
